// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam logic [2:0] WIDTH_WORD = 3'b010;

endpackage

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - combinational 2-way round-robin picker (bit 0 = fetch, bit 1 = load/store)
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       enable,
  output logic [1:0] gnt,
  output logic       owner
);

  always_comb begin
    gnt   = 2'b00;
    owner = last_owner;
    if (enable) begin
      case (req)
        2'b01: begin
          gnt   = 2'b01;
          owner = OWN_IF;
        end
        2'b10: begin
          gnt   = 2'b10;
          owner = OWN_D;
        end
        2'b11: begin
          // A tie goes to whichever port did not win last time.
          if (last_owner == OWN_D) begin
            gnt   = 2'b01;
            owner = OWN_IF;
          end else begin
            gnt   = 2'b10;
            owner = OWN_D;
          end
        end
        default: begin
          gnt   = 2'b00;
          owner = last_owner;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between fetch and load/store ports
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_width,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_width,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  if (MEM_LATENCY < 1) begin : g_latency_check
    $error("mem_port_arbiter: MEM_LATENCY must be >= 1");
  end

  arb_state_t        state_q;
  owner_t            last_owner_q;
  owner_t            owner_q;
  logic              we_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [2:0]        mem_width_q;
  logic              if_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic              d_rvalid_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic [1:0]        gnt;
  logic              new_owner;
  logic              grant_en;
  logic              any_gnt;

  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic [2:0]        lat_width;

  // Grants are masked by reset so nothing is accepted while the block is held in reset.
  assign grant_en = reset && ((state_q == IDLE) || (state_q == RESP));

  arb_rr2 u_rr (
    .req        ({d_req, if_req}),
    .last_owner (last_owner_q),
    .enable     (grant_en),
    .gnt        (gnt),
    .owner      (new_owner)
  );

  assign if_gnt  = gnt[0];
  assign d_gnt   = gnt[1];
  assign any_gnt = |gnt;

  always_comb begin
    lat_addr  = if_addr;
    lat_we    = 1'b0;
    lat_wdata = '0;
    lat_width = WIDTH_WORD;
    if (gnt[1]) begin
      lat_addr  = d_addr;
      lat_we    = d_we;
      lat_wdata = d_wdata;
      lat_width = d_width;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_D;
      owner_q      <= OWN_IF;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_width_q  <= '0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      d_rvalid_q   <= 1'b0;
      d_rdata_q    <= '0;
    end else begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_width_q <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;

      case (state_q)
        IDLE, RESP: begin
          if (any_gnt) begin
            state_q      <= ISSUE;
            owner_q      <= owner_t'(new_owner);
            last_owner_q <= owner_t'(new_owner);
            we_q         <= lat_we;
            mem_en_q     <= 1'b1;
            mem_we_q     <= lat_we;
            mem_addr_q   <= lat_addr;
            mem_wdata_q  <= lat_wdata;
            mem_width_q  <= lat_width;
          end else begin
            state_q <= IDLE;
          end
        end

        ISSUE: begin
          cnt_q   <= CNT_W'(MEM_LATENCY - 1);
          state_q <= WAIT;
        end

        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
            if (owner_q == OWN_IF) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= mem_rdata;
            end else begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= we_q ? '0 : mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_width = mem_width_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter at latency 2 and latency 1
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  always #5 clk = ~clk;

  logic        if_req = 0, if_gnt, if_rvalid;
  logic [31:0] if_addr = 0, if_rdata;
  logic        d_req = 0, d_we = 0, d_gnt, d_rvalid;
  logic [31:0] d_addr = 0, d_wdata = 0, d_rdata;
  logic [2:0]  d_width = 0;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_width;

  logic        b_if_req = 0, b_if_gnt, b_if_rvalid;
  logic [31:0] b_if_addr = 0, b_if_rdata;
  logic        b_d_gnt, b_d_rvalid;
  logic [31:0] b_d_rdata;
  logic        b_mem_en, b_mem_we;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [2:0]  b_mem_width;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata), .d_width(d_width),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_width(mem_width), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(1'b0), .d_addr(32'h0), .d_we(1'b0), .d_wdata(32'h0), .d_width(3'b000),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_width(b_mem_width), .mem_rdata(b_mem_rdata)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : a + 32'h1000_0000;
  endfunction

  // Memory models: address captured on the strobe, data valid from the following cycle on.
  logic [31:0] rd_a = 0, b_rd_a = 0;
  always @(posedge clk) begin
    if (mem_en) rd_a <= mem_addr;
    if (b_mem_en) b_rd_a <= b_mem_addr;
  end
  assign mem_rdata   = mem_val(rd_a);
  assign b_mem_rdata = mem_val(b_rd_a);

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [2:0]  dw;
    logic [1:0]  g;
    logic [31:0] ma;
    logic        mwe;
    logic [31:0] mwd;
    logic [2:0]  mw;
    logic [31:0] rd;
  } vec_t;

  vec_t        tbl[8];
  vec_t        v;
  logic [31:0] last_if, last_d;
  logic [4:0]  ex;

  initial begin
    tbl[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000,
               2'b01, 32'h100, 1'b0, 32'h0, 3'b010, 32'hDEADBEEF};
    tbl[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'h12345678, 3'b001,
               2'b10, 32'h2000, 1'b1, 32'h12345678, 3'b001, 32'h0};
    tbl[2] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h0, 3'b100,
               2'b01, 32'h40, 1'b0, 32'h0, 3'b010, 32'h10000040};
    tbl[3] = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h84, 32'h0, 3'b101,
               2'b10, 32'h84, 1'b0, 32'h0, 3'b101, 32'h10000084};
    tbl[4] = '{1'b1, 32'h48, 1'b1, 1'b1, 32'h88, 32'hCAFEF00D, 3'b010,
               2'b01, 32'h48, 1'b0, 32'h0, 3'b010, 32'h10000048};
    tbl[5] = '{1'b1, 32'h4C, 1'b1, 1'b1, 32'h8C, 32'hCAFEF00D, 3'b010,
               2'b10, 32'h8C, 1'b1, 32'hCAFEF00D, 3'b010, 32'h0};
    tbl[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 3'b000,
               2'b10, 32'hFFFFFFFC, 1'b0, 32'h0, 3'b000, 32'h0FFFFFFC};
    tbl[7] = '{1'b1, 32'h3, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000,
               2'b01, 32'h3, 1'b0, 32'h0, 3'b010, 32'h10000003};

    // Reset state, with both requests high to show grants are held off.
    if_req = 1; d_req = 1;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, mem_width}, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);
    chk("rst_mem", {mem_addr, mem_wdata}, 0);
    if_req = 0; d_req = 0;
    reset = 1;
    tick();

    // Both requests held: IF first after reset, then alternate, one strobe every LAT+2 cycles.
    if_req = 1; d_req = 1; if_addr = 32'h300; d_addr = 32'h400; d_we = 0; d_width = 3'b010;
    for (int c = 0; c < 18; c++) begin
      if (c == 13) begin if_req = 0; d_req = 0; end
      @(negedge clk);
      ex = {c == 0 || c == 8, c == 4 || c == 12, c == 1 || c == 5 || c == 9 || c == 13,
            c == 4 || c == 12, c == 8 || c == 16};
      chk($sformatf("rr_c%0d", c), {if_gnt, d_gnt, mem_en, if_rvalid, d_rvalid}, ex);
      if (c == 1 || c == 9) chk($sformatf("rr_addr_c%0d", c), mem_addr, 32'h300);
      if (c == 5 || c == 13) chk($sformatf("rr_addr_c%0d", c), mem_addr, 32'h400);
      if (c == 4 || c == 12) chk($sformatf("rr_ifdata_c%0d", c), if_rdata, 32'h10000300);
      if (c == 8 || c == 16) chk($sformatf("rr_ddata_c%0d", c), d_rdata, 32'h10000400);
      tick();
    end

    // Table of single transactions from IDLE; reset first so the first tie goes to fetch.
    reset = 0;
    tick();
    reset = 1;
    last_if = 0; last_d = 0;
    for (int i = 0; i < 8; i++) begin
      v = tbl[i];
      if_req = v.ir; if_addr = v.ia; d_req = v.dr; d_we = v.dwe;
      d_addr = v.da; d_wdata = v.dwd; d_width = v.dw;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), {d_gnt, if_gnt}, v.g);
      tick();
      if_req = 0; d_req = 0;
      @(negedge clk);
      chk($sformatf("v%0d_issue", i), {mem_en, mem_we, mem_width, mem_addr}, {1'b1, v.mwe, v.mw, v.ma});
      chk($sformatf("v%0d_wdata", i), mem_wdata, v.mwd);
      @(negedge clk);
      chk($sformatf("v%0d_wait", i), {mem_en, mem_we, mem_width, mem_addr, mem_wdata}, 0);
      repeat (LAT) @(negedge clk);
      chk($sformatf("v%0d_rvalid", i), {d_rvalid, if_rvalid}, v.g);
      if (v.g[0]) last_if = v.rd;
      else last_d = v.rd;
      chk($sformatf("v%0d_rdata", i), {if_rdata, d_rdata}, {last_if, last_d});
      tick();
    end

    // Reset in WAIT drops the transaction; a held request is re-granted afterwards.
    if_req = 1; if_addr = 32'h500; d_req = 0;
    tick();
    tick();
    reset = 0;
    #1;
    chk("rstw_now", {if_gnt, d_gnt, mem_en, if_rvalid, d_rvalid}, 0);
    chk("rstw_rdata", {if_rdata, d_rdata}, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rstw_hold%0d", c), {if_gnt, d_gnt, mem_en, if_rvalid, d_rvalid}, 0);
    end
    @(posedge clk);
    #1;
    reset = 1;
    for (int c = 0; c < 8; c++) begin
      if (c == 1) if_req = 0;
      @(negedge clk);
      ex = {c == 0, 1'b0, c == 1, c == 4, 1'b0};
      chk($sformatf("rstw_c%0d", c), {if_gnt, d_gnt, mem_en, if_rvalid, d_rvalid}, ex);
      if (c == 4) chk("rstw_data", if_rdata, 32'h10000500);
      tick();
    end

    // Latency 1: back-to-back fetches from 0x0 and 0x4.
    b_if_req = 1; b_if_addr = 32'h0;
    for (int c = 0; c < 8; c++) begin
      if (c == 1) b_if_addr = 32'h4;
      if (c == 4) b_if_req = 0;
      @(negedge clk);
      ex = {c == 0 || c == 3, 1'b0, c == 1 || c == 4, c == 3 || c == 6, 1'b0};
      chk($sformatf("l1_c%0d", c), {b_if_gnt, b_d_gnt, b_mem_en, b_if_rvalid, b_d_rvalid}, ex);
      if (c == 1) chk("l1_addr0", b_mem_addr, 32'h0);
      if (c == 4) chk("l1_addr1", b_mem_addr, 32'h4);
      if (c == 3) chk("l1_data0", b_if_rdata, 32'h10000000);
      if (c == 6) chk("l1_data1", b_if_rdata, 32'h10000004);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between the core's instruction-fetch port and its load/store port. It grants one requester at a time using 2-way round-robin, issues the access to memory, and waits a fixed memory latency. It then returns read data or a write acknowledge to the winning requester. It sits between the core's data path and the memory model, replacing separate instruction and data memories.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata; must be >=1 (elaboration assertion)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  one-cycle pulse, fetch data valid
if_rdata  out  DATA_W  fetch data
d_req  in  1  load/store request; held until d_gnt
d_addr  in  ADDR_W  load/store address
d_we  in  1  1=store
d_wdata  in  DATA_W  store data
d_width  in  3  funct3 width code (byte/half/word, signed/unsigned)
d_gnt  out  1  load/store request accepted this cycle
d_rvalid  out  1  one-cycle pulse, load data valid or store done
d_rdata  out  DATA_W  load data; 0 for stores
mem_en  out  1  memory access strobe, one cycle
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_width  out  3  memory width code
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (reset low, async) forces state=IDLE and last_owner=OWN_D.
  - All outputs are 0 on reset. if_gnt and d_gnt are forced 0 while reset is low.
  - An in-flight transaction is dropped: no rvalid is ever produced for it, and the requester must re-request.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- Grant is combinational and allowed only in IDLE or RESP. At most one gnt is high per cycle.
- Only one req high: grant it.
- Both reqs high: grant the port that is not last_owner. The first tie after reset goes to fetch.
- On grant (cycle 0), the block latches owner, addr, we, wdata and width, and updates last_owner.
  - Fetch latches we=0, wdata=0, width=3'b010.
- Next state after grant is ISSUE.
- ISSUE (cycle 1):
  - mem_en=1 and the mem_* outputs drive the latched values.
  - The latency counter loads MEM_LATENCY-1.
  - Next state is WAIT.
- WAIT (cycles 2..1+MEM_LATENCY):
  - mem_en=0, and mem_addr, mem_we, mem_width and mem_wdata return to 0.
  - The counter decrements each cycle.
  - When the counter reaches 0, mem_rdata is captured (forced to 0 for stores) and the next state is RESP.
- RESP (cycle 2+MEM_LATENCY):
  - The owner's rvalid=1 and its rdata holds the captured value.
  - The non-owner's rvalid stays 0.
  - If a new grant occurs in RESP, next state is ISSUE; otherwise IDLE.
- Throughput: one transaction per MEM_LATENCY+2 cycles when back-to-back.
- rdata holds its last value until the next rvalid for that port.
- A req asserted during ISSUE or WAIT gets no gnt and waits.
- A req deasserted after its grant has no effect on the transaction.
- Addresses pass through unchanged; no alignment checks are performed.

Decomposition:
- mem_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, ISSUE, WAIT, RESP}
  - typedef enum owner_t {OWN_IF, OWN_D}
  - constant WIDTH_WORD=3'b010
- One sub-module, arb_rr2: a 2-way round-robin picker.
  - Inputs: req[1:0], last_owner, enable.
  - Outputs: one-hot gnt[1:0] and the new owner.
  - Purely combinational.

Test Plan:
- Single fetch read, MEM_LATENCY=2: if_req with if_addr=0x100 at cycle 0; memory returns 0xDEADBEEF at cycle 3.
  -> if_gnt at cycle 0; mem_en at cycle 1 with addr 0x100, we=0, width 010; if_rvalid at cycle 4 with if_rdata=0xDEADBEEF; d_rvalid stays 0.
- Simultaneous if_req and d_req right after reset.
  -> if_gnt first; d_gnt in the RESP cycle of the fetch transaction; d transaction mem_en follows one cycle later.
- Both reqs held high for 4 transactions.
  -> grant order IF, D, IF, D; one mem_en every MEM_LATENCY+2 cycles; each rvalid routed to the correct port.
- Store: d_we=1, d_addr=0x2000, d_wdata=0x12345678, d_width=001.
  -> mem_en and mem_we high together with those values in ISSUE; d_rvalid pulse with d_rdata=0.
- reset driven low during WAIT.
  -> mem_en, rvalid and gnt drop to 0 immediately. After release, a held if_req is re-granted from IDLE and no stale rvalid appears.
- MEM_LATENCY=1, back-to-back fetches from 0x0 and 0x4.
  -> mem_en on cycles 1 and 4; if_rvalid on cycles 3 and 6.
